elevator_controller: RTL and testbench
======================================

// Module: elevator_controller
// PURPOSE
//  Sequencing controller for a single elevator car. Latches floor call buttons,
//  selects travel direction (SCAN: keep direction while calls remain ahead),
//  and drives the engine/door command buses of the car plant from its sensors.
//  Sits between the button panel and the car plant model or real car I/O.
// PARAMETERS
//  BUTTONS_WIDTH  8    number of floors; one call button per floor
//  FLOOR_W        3    floor index width; must satisfy 2**FLOOR_W >= BUTTONS_WIDTH
//  DOOR_DWELL     16   cycles the door is held open (door=0) before closing
//  MOVE_TIMEOUT   1000 max cycles in MOVE without a floor sensor pulse before FAULT
// PORTS
//  clock        in   1              system clock, rising edge
//  a_reset      in   1              asynchronous reset, active-high
//  buttons      in   BUTTONS_WIDTH  call requests; level or pulse, bit i = floor i
//  sensor_door  in   2              0 between, 1 open reached, 2 closed reached
//  sensor_up    in   1              floor-reached pulse while moving up
//  sensor_down  in   1              floor-reached pulse while moving down
//  engine       out  2              0 idle, 1 down, 2 up (registered)
//  door         out  2              0 idle, 1 open, 2 close (registered)
//  floor        out  FLOOR_W        current car floor (registered)
//  pending      out  BUTTONS_WIDTH  latched, not yet served calls
//  dir_up       out  1              1 = current/last travel direction up
//  fault        out  1              move watchdog expired; sticky until reset
// BEHAVIOUR
//  Reset (async, a_reset=1): state IDLE; engine=0, door=0, floor=0, pending=0,
//   dir_up=1, fault=0, all counters 0. Car assumed at floor 0 with door closed.
//  Call latching: pending <= (pending | buttons) & ~served, where served is
//   one-hot current floor in OPEN/DWELL, else 0. Press at edge n visible at n+1.
//  Outputs are registered; commands change one cycle after the triggering input.
//  req_above = |pending bits > floor; req_below = |pending bits < floor.
//  States:
//   IDLE  engine=0, door=0. If pending[floor] -> OPEN. Else if dir_up&req_above
//         -> MOVE up; else if req_below -> MOVE down (dir_up=0); else if
//         req_above -> MOVE up (dir_up=1); else stay.
//   MOVE  engine = dir_up ? 2 : 1. Sensor pulse of matching direction (sensor_up
//         when up, sensor_down when down) -> floor +/-1, watchdog cleared. Then if
//         pending[new floor] -> OPEN (engine=0); else if no calls remain ahead ->
//         IDLE (engine=0; reversal always passes through IDLE). Pulse of other
//         direction ignored. floor saturates at 0 and BUTTONS_WIDTH-1; pulse at a
//         limit -> IDLE without changing floor. Watchdog reaching MOVE_TIMEOUT ->
//         FAULT.
//   OPEN  door=1 held until sensor_door==1, then DWELL (door=0, dwell cnt=0).
//   DWELL door=0; counts DOOR_DWELL cycles then -> CLOSE. buttons[floor] during
//         DWELL restarts count at 0 and is not latched.
//   CLOSE door=2 held until sensor_door==2, then IDLE (door=0).
//   FAULT engine=0, door=0, fault=1; buttons still latch; exit only by reset.
//  sensor_door ignored outside OPEN/CLOSE; sensor_up/down ignored outside MOVE.
//  sensor_door==2 seen in OPEN (or 1 in CLOSE) is ignored; command held.
//  engine and door are never both non-zero in the same cycle.
//  Simultaneous sensor_up & sensor_down: only the matching-direction one counts.
//  Reset mid-operation: immediate return to reset values, pending calls discarded.
// TESTING
//  1 Assert a_reset mid-MOVE -> engine=0, door=0, floor=0, pending=0, fault=0 at once.
//  2 IDLE floor 0, pulse buttons[3] -> pending=0x08, engine=2; three sensor_up
//    pulses -> floor=3, engine=0, door=1; sensor_door=1 -> door=0 for 16 cycles,
//    door=2; sensor_door=2 -> IDLE, pending=0.
//  3 Floor 0, press 5 then 2 while between 0 and 1 -> stops at 2 (door cycle),
//    resumes up, stops at 5; press 1 at 5 -> after close, engine=1, dir_up=0.
//  4 IDLE floor 4, pulse buttons[4] -> door=1 next cycle, engine stays 0.
//  5 MOVE up, no sensor pulses for 1000 cycles -> fault=1, engine=0; stays until reset.
//  6 During DWELL, pulse buttons[floor] at count 10 -> door stays 0 a further
//    16 cycles; pending[floor] stays 0.

Source files
------------

// File: rtl/elevator_controller.sv
// elevator_controller: SCAN-scheduled single-car controller; latches floor calls and
// drives registered engine/door commands from the car's floor and door sensors.
module elevator_controller #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_W       = 3,
    parameter int DOOR_DWELL    = 16,
    parameter int MOVE_TIMEOUT  = 1000
) (
    input  logic                     clock,
    input  logic                     a_reset,
    input  logic [BUTTONS_WIDTH-1:0] buttons,
    input  logic [1:0]               sensor_door,
    input  logic                     sensor_up,
    input  logic                     sensor_down,
    output logic [1:0]               engine,
    output logic [1:0]               door,
    output logic [FLOOR_W-1:0]       floor,
    output logic [BUTTONS_WIDTH-1:0] pending,
    output logic                     dir_up,
    output logic                     fault
);
    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_OPEN, S_DWELL, S_CLOSE, S_FAULT} state_t;
    localparam int WD_W = $clog2(MOVE_TIMEOUT + 1);
    localparam int DW_W = $clog2(DOOR_DWELL + 1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(BUTTONS_WIDTH - 1);

    state_t                   r_state, w_state;
    logic [FLOOR_W-1:0]       r_floor, w_floor, w_nf;
    logic [BUTTONS_WIDTH-1:0] r_pending, w_req, w_served;
    logic                     r_dir_up, w_dir_up, r_fault;
    logic [1:0]               r_engine, w_engine, r_door, w_door;
    logic [WD_W-1:0]          r_wdog, w_wdog;
    logic [DW_W-1:0]          r_dwell, w_dwell;
    logic                     w_above, w_below, w_go_up, w_hit, w_limit, w_ahead;

    function automatic logic [BUTTONS_WIDTH-1:0] side_mask(input logic [FLOOR_W-1:0] f, input logic up);
        logic [BUTTONS_WIDTH-1:0] m;
        for (int i = 0; i < BUTTONS_WIDTH; i++) m[i] = up ? (i > int'(f)) : (i < int'(f));
        return m;
    endfunction

    // Decisions see this cycle's presses so commands follow a press by one cycle.
    assign w_req    = r_pending | buttons;
    assign w_served = (r_state == S_OPEN || r_state == S_DWELL) ? BUTTONS_WIDTH'(1) << r_floor : '0;
    assign w_above  = |(w_req & side_mask(r_floor, 1'b1));
    assign w_below  = |(w_req & side_mask(r_floor, 1'b0));
    assign w_go_up  = r_dir_up ? w_above : !w_below;
    assign w_hit    = r_dir_up ? sensor_up : sensor_down;
    assign w_limit  = r_dir_up ? (r_floor == TOP) : (r_floor == '0);
    assign w_nf     = r_dir_up ? r_floor + 1'b1 : r_floor - 1'b1;
    assign w_ahead  = |(w_req & side_mask(w_nf, r_dir_up));

    always_comb begin
        w_state  = r_state;
        w_floor  = r_floor;
        w_dir_up = r_dir_up;
        w_wdog   = r_wdog;
        w_dwell  = r_dwell;
        w_engine = 2'd0;
        w_door   = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (w_req[r_floor]) begin
                    w_state = S_OPEN;
                    w_door  = 2'd1;
                end else if (w_above || w_below) begin
                    w_state  = S_MOVE;
                    w_dir_up = w_go_up;
                    w_engine = w_go_up ? 2'd2 : 2'd1;
                    w_wdog   = '0;
                end
            end
            S_MOVE: begin
                w_engine = r_dir_up ? 2'd2 : 2'd1;
                if (w_hit) begin
                    w_wdog = '0;
                    if (w_limit) begin
                        w_state  = S_IDLE;
                        w_engine = 2'd0;
                    end else begin
                        w_floor = w_nf;
                        if (w_req[w_nf]) begin
                            w_state  = S_OPEN;
                            w_engine = 2'd0;
                            w_door   = 2'd1;
                        end else if (!w_ahead) begin
                            w_state  = S_IDLE;
                            w_engine = 2'd0;
                        end
                    end
                end else if (r_wdog == WD_W'(MOVE_TIMEOUT - 1)) begin
                    w_state  = S_FAULT;
                    w_engine = 2'd0;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
            end
            S_OPEN: begin
                w_state = sensor_door == 2'd1 ? S_DWELL : S_OPEN;
                w_door  = sensor_door == 2'd1 ? 2'd0 : 2'd1;
                w_dwell = '0;
            end
            S_DWELL: begin
                if (buttons[r_floor]) begin
                    w_dwell = '0;
                end else if (r_dwell == DW_W'(DOOR_DWELL - 1)) begin
                    w_state = S_CLOSE;
                    w_door  = 2'd2;
                end else begin
                    w_dwell = r_dwell + 1'b1;
                end
            end
            S_CLOSE: begin
                w_state = sensor_door == 2'd2 ? S_IDLE : S_CLOSE;
                w_door  = sensor_door == 2'd2 ? 2'd0 : 2'd2;
            end
            S_FAULT: w_state = S_FAULT;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge a_reset) begin
        if (a_reset) begin
            r_state   <= S_IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_fault   <= 1'b0;
            r_engine  <= 2'd0;
            r_door    <= 2'd0;
            r_wdog    <= '0;
            r_dwell   <= '0;
        end else begin
            r_state   <= w_state;
            r_floor   <= w_floor;
            r_pending <= w_req & ~w_served;
            r_dir_up  <= w_dir_up;
            r_fault   <= w_state == S_FAULT;
            r_engine  <= w_engine;
            r_door    <= w_door;
            r_wdog    <= w_wdog;
            r_dwell   <= w_dwell;
        end
    end

    assign engine  = r_engine;
    assign door    = r_door;
    assign floor   = r_floor;
    assign pending = r_pending;
    assign dir_up  = r_dir_up;
    assign fault   = r_fault;
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: bench for elevator_controller; a car model predicts every
// registered output and also acts as the car plant, answering its own commands.
module tb_elevator_controller;
    localparam int NB    = 8;
    localparam int DWELL = 16;
    localparam int TMO   = 1000;

    logic          clock = 1'b0, a_reset = 1'b1;
    logic [NB-1:0] buttons = '0;
    logic [1:0]    sensor_door = '0;
    logic          sensor_up = 1'b0, sensor_down = 1'b0;
    logic [1:0]    engine, door;
    logic [2:0]    floor;
    logic [NB-1:0] pending;
    logic          dir_up, fault;

    int            total = 0, bad = 0;
    logic [16:0]   exp_q[$];
    logic [16:0]   mon_e;

    int            m_floor, m_engine, m_door, m_dwell, m_quiet;
    logic [NB-1:0] m_pend;
    logic          m_up, m_fault;

    logic [NB-1:0] rb;
    logic [1:0]    rsd;
    logic          rsu, rsdn, pulse;

    elevator_controller dut (
        .clock(clock), .a_reset(a_reset), .buttons(buttons), .sensor_door(sensor_door),
        .sensor_up(sensor_up), .sensor_down(sensor_down), .engine(engine), .door(door),
        .floor(floor), .pending(pending), .dir_up(dir_up), .fault(fault)
    );

    always #5 clock = ~clock;

    function automatic logic calls_ahead(input logic [NB-1:0] req, input int f, input logic up);
        for (int i = 0; i < NB; i++)
            if (req[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Car behaviour for one clock edge, given the inputs presented before it.
    task automatic model(input logic r, input logic [NB-1:0] b, input logic [1:0] sd, input logic su, input logic sdn);
        logic [NB-1:0] req;
        logic serving;
        if (r) begin
            m_floor = 0; m_engine = 0; m_door = 0; m_dwell = 0; m_quiet = 0;
            m_pend = '0; m_up = 1'b1; m_fault = 1'b0;
            return;
        end
        req = m_pend | b;
        serving = m_door == 1 || m_dwell > 0;
        m_pend = serving ? req & ~(NB'(1) << m_floor) : req;
        if (m_fault) begin
        end else if (m_door == 1) begin
            if (sd == 2'd1) begin m_door = 0; m_dwell = DWELL; end
        end else if (m_dwell > 0) begin
            if (b[m_floor]) m_dwell = DWELL;
            else begin
                m_dwell--;
                if (m_dwell == 0) m_door = 2;
            end
        end else if (m_door == 2) begin
            if (sd == 2'd2) m_door = 0;
        end else if (m_engine != 0) begin
            if (m_up ? su : sdn) begin
                m_quiet = 0;
                if (m_up ? m_floor == NB - 1 : m_floor == 0) m_engine = 0;
                else begin
                    m_floor += m_up ? 1 : -1;
                    if (req[m_floor]) begin m_engine = 0; m_door = 1; end
                    else if (!calls_ahead(req, m_floor, m_up)) m_engine = 0;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TMO) begin m_engine = 0; m_fault = 1'b1; end
            end
        end else if (req[m_floor]) begin
            m_door = 1;
        end else if (calls_ahead(req, m_floor, 1'b1) || calls_ahead(req, m_floor, 1'b0)) begin
            m_up = calls_ahead(req, m_floor, m_up) ? m_up : !m_up;
            m_engine = m_up ? 2 : 1;
            m_quiet = 0;
        end
    endtask

    task automatic step(input logic r, input logic [NB-1:0] b, input logic [1:0] sd, input logic su, input logic sdn);
        @(negedge clock);
        a_reset = r; buttons = b; sensor_door = sd; sensor_up = su; sensor_down = sdn;
        model(r, b, sd, su, sdn);
        exp_q.push_back({2'(m_engine), 2'(m_door), 3'(m_floor), m_pend, m_up, m_fault});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic after_edge;
        @(posedge clock);
        #2;
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if ({engine, door, floor, pending, dir_up, fault} !== mon_e) begin
                bad++;
                $display("FAIL outputs @%0t: got eng=%0d door=%0d floor=%0d pend=%02h up=%0b fault=%0b, want eng=%0d door=%0d floor=%0d pend=%02h up=%0b fault=%0b",
                         $time, engine, door, floor, pending, dir_up, fault,
                         mon_e[16:15], mon_e[14:13], mon_e[12:10], mon_e[9:2], mon_e[1], mon_e[0]);
            end
        end
    end

    initial begin
        model(1'b1, '0, 2'd0, 1'b0, 1'b0);
        step(1'b1, '0, 2'd0, 1'b0, 1'b0);
        step(1'b1, '0, 2'd0, 1'b0, 1'b0);
        after_edge;
        chk("reset floor", floor, 0);
        chk("reset dir_up", dir_up, 1);
        chk("reset engine", engine, 0);
        // call to floor 3 from floor 0, full door cycle
        step(1'b0, 8'h08, 2'd0, 1'b0, 1'b0);
        after_edge;
        chk("t2 pending", pending, 8);
        chk("t2 engine up", engine, 2);
        repeat (3) begin
            step(1'b0, '0, 2'd0, 1'b1, 1'b0);
            idle(2);
        end
        after_edge;
        chk("t2 floor", floor, 3);
        chk("t2 engine stop", engine, 0);
        chk("t2 door open", door, 1);
        step(1'b0, '0, 2'd1, 1'b0, 1'b0);
        after_edge;
        chk("t2 dwell start", door, 0);
        idle(15);
        after_edge;
        chk("t2 dwell end", door, 0);
        idle(1);
        after_edge;
        chk("t2 door close", door, 2);
        step(1'b0, '0, 2'd2, 1'b0, 1'b0);
        after_edge;
        chk("t2 idle door", door, 0);
        chk("t2 pending clear", pending, 0);
        // reach floor 4, then press 4 while idle there
        step(1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0);
        step(1'b0, '0, 2'd1, 1'b0, 1'b0);
        idle(DWELL);
        step(1'b0, '0, 2'd2, 1'b0, 1'b0);
        step(1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        after_edge;
        chk("t4 door open", door, 1);
        chk("t4 engine idle", engine, 0);
        // dwell restart by the current floor's button at count 10
        step(1'b0, '0, 2'd1, 1'b0, 1'b0);
        idle(10);
        step(1'b0, 8'h10, 2'd0, 1'b0, 1'b0);
        idle(15);
        after_edge;
        chk("t6 dwell extended", door, 0);
        chk("t6 pending[4]", pending[4], 0);
        idle(1);
        after_edge;
        chk("t6 door close", door, 2);
        step(1'b0, '0, 2'd2, 1'b0, 1'b0);
        // reset while moving up
        step(1'b0, 8'h80, 2'd0, 1'b0, 1'b0);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0);
        step(1'b1, '0, 2'd0, 1'b0, 1'b0);
        #1;
        chk("t1 engine", engine, 0);
        chk("t1 door", door, 0);
        chk("t1 floor", floor, 0);
        chk("t1 pending", pending, 0);
        chk("t1 fault", fault, 0);
        // SCAN: 5 then 2 pressed, stop at 2, continue to 5, then reverse for 1
        step(1'b0, 8'h20, 2'd0, 1'b0, 1'b0);
        step(1'b0, 8'h04, 2'd0, 1'b0, 1'b0);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0);
        after_edge;
        chk("t3 stop floor", floor, 2);
        chk("t3 stop door", door, 1);
        step(1'b0, '0, 2'd1, 1'b0, 1'b0);
        idle(DWELL);
        step(1'b0, '0, 2'd2, 1'b0, 1'b0);
        idle(1);
        after_edge;
        chk("t3 resume up", engine, 2);
        repeat (3) step(1'b0, '0, 2'd0, 1'b1, 1'b0);
        after_edge;
        chk("t3 top floor", floor, 5);
        chk("t3 top door", door, 1);
        step(1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b0, 8'h02, 2'd0, 1'b0, 1'b0);
        idle(15);
        step(1'b0, '0, 2'd2, 1'b0, 1'b0);
        idle(1);
        after_edge;
        chk("t3 reverse engine", engine, 1);
        chk("t3 reverse dir", dir_up, 0);
        // move watchdog
        step(1'b1, '0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 8'h08, 2'd0, 1'b0, 1'b0);
        idle(TMO - 1);
        after_edge;
        chk("t5 no fault yet", fault, 0);
        chk("t5 still moving", engine, 2);
        idle(1);
        after_edge;
        chk("t5 fault", fault, 1);
        chk("t5 engine stop", engine, 0);
        step(1'b0, 8'h40, 2'd1, 1'b1, 1'b0);
        idle(4);
        after_edge;
        chk("t5 fault sticky", fault, 1);
        chk("t5 latch in fault", pending, 8'h48);
        step(1'b1, '0, 2'd0, 1'b0, 1'b0);
        // random calls with the model acting as the car plant
        repeat (3000) begin
            rb = ($urandom_range(0, 9) == 0) ? NB'(1) << $urandom_range(0, NB - 1) : '0;
            pulse = $urandom_range(0, 4) == 0;
            rsu  = (m_engine != 0 && m_up)  ? pulse : ($urandom_range(0, 9) == 0);
            rsdn = (m_engine != 0 && !m_up) ? pulse : ($urandom_range(0, 9) == 0);
            if (m_door == 1) rsd = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'($urandom_range(0, 1) * 2);
            else if (m_door == 2) rsd = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
            else rsd = 2'($urandom_range(0, 2));
            step($urandom_range(0, 599) == 0, rb, rsd, rsu, rsdn);
        end
        after_edge;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
